// File: rtl/instr_fetch_unit.sv
// Purpose : instruction fetch front end; fetches words from imem, holds them in IR, issues opcode once to the control unit.
// Latency : 4 cycles per instruction (FETCH, HOLD, ISSUE, RESOLVE) with zero-latency imem and no stall.
// Backpr. : stall holds the instruction in HOLD; imem_req is held with a stable address until imem_valid.
//
// Ports:
//   clk, rst        - clock, synchronous active-high reset
//   imem_req/addr   - fetch request and address (= pc), held until imem_valid
//   imem_rdata/valid- instruction word and its response strobe
//   stall           - downstream busy, delays issue while in HOLD
//   jmp_op          - registered jump decision from the control unit, sampled in RESOLVE
//   opcode/operand  - IR fields to the control unit; opcode is NOP (3'b101) except in ISSUE
//   pc_out          - PC of the instruction held in IR
//   halted          - HALT instruction reached (or fetch timeout)
//   fetch_err       - sticky fetch timeout flag
//
// Optional feature macro: FETCH_TIMEOUT_EN (fetch wait counter; halts with fetch_err after TIMEOUT cycles).
// All outputs come straight from registers.

module instr_fetch_unit #(
    parameter int                INSTR_W  = 16,
    parameter int                ADDR_W   = 8,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter int                TIMEOUT  = 15
) (
    input  logic               clk,
    input  logic               rst,
    output logic               imem_req,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic [INSTR_W-1:0] imem_rdata,
    input  logic               imem_valid,
    input  logic               stall,
    input  logic               jmp_op,
    output logic [2:0]         opcode,
    output logic [INSTR_W-4:0] operand,
    output logic [ADDR_W-1:0]  pc_out,
    output logic               halted,
    output logic               fetch_err
);

    localparam logic [2:0] OP_NOP  = 3'b101;
    localparam logic [2:0] OP_HALT = 3'b111;

    // Jump target is taken from the low IR bits, so it must fit below the opcode field.
    if (ADDR_W > INSTR_W - 3 || TIMEOUT < 1) begin : g_bad_cfg
        $error("instr_fetch_unit: invalid parameter combination");
    end

    typedef enum logic [2:0] {
        S_FETCH,
        S_HOLD,
        S_ISSUE,
        S_RESOLVE,
        S_HALTED
    } state_t;

    state_t             state_q,    state_d;
    logic [ADDR_W-1:0]  pc_q,       pc_d;
    logic [INSTR_W-1:0] ir_q,       ir_d;
    logic               imem_req_q, imem_req_d;
    logic [2:0]         opcode_q,   opcode_d;
    logic               halted_q,   halted_d;
    logic               err_q,      err_d;

`ifdef FETCH_TIMEOUT_EN
    localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
    logic [CNT_W-1:0]   wait_cnt_q, wait_cnt_d;
`endif

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ir_d    = ir_q;
        err_d   = err_q;
`ifdef FETCH_TIMEOUT_EN
        wait_cnt_d = '0;
`endif
        case (state_q)
            S_FETCH: begin
                // A response only counts while our request is actually on the bus;
                // this also covers the idle cycle right after reset.
                if (imem_req_q && imem_valid) begin
                    ir_d    = imem_rdata;
                    state_d = S_HOLD;
                end
`ifdef FETCH_TIMEOUT_EN
                else if (imem_req_q) begin
                    if (wait_cnt_q == CNT_W'(TIMEOUT - 1)) begin
                        err_d   = 1'b1;
                        state_d = S_HALTED;
                    end else begin
                        wait_cnt_d = wait_cnt_q + CNT_W'(1);
                    end
                end
`endif
            end
            S_HOLD: begin
                // HALT is never issued to the control unit.
                if (ir_q[INSTR_W-1 -: 3] == OP_HALT) begin
                    state_d = S_HALTED;
                end else if (!stall) begin
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                state_d = S_RESOLVE;
            end
            S_RESOLVE: begin
                // jmp_op is the control unit's registered response to the opcode seen in ISSUE.
                if (jmp_op) begin
                    pc_d = ir_q[ADDR_W-1:0];
                end else begin
                    pc_d = pc_q + ADDR_W'(1);
                end
                state_d = S_FETCH;
            end
            S_HALTED: begin
                state_d = S_HALTED;
            end
            default: begin
                state_d = S_FETCH;
            end
        endcase

        // Registered outputs are computed from the next state so they line up with it.
        imem_req_d = (state_d == S_FETCH);
        opcode_d   = (state_d == S_ISSUE) ? ir_d[INSTR_W-1 -: 3] : OP_NOP;
        halted_d   = (state_d == S_HALTED);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_FETCH;
            pc_q       <= RESET_PC;
            ir_q       <= '0;
            imem_req_q <= 1'b0;
            opcode_q   <= OP_NOP;
            halted_q   <= 1'b0;
            err_q      <= 1'b0;
`ifdef FETCH_TIMEOUT_EN
            wait_cnt_q <= '0;
`endif
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            ir_q       <= ir_d;
            imem_req_q <= imem_req_d;
            opcode_q   <= opcode_d;
            halted_q   <= halted_d;
            err_q      <= err_d;
`ifdef FETCH_TIMEOUT_EN
            wait_cnt_q <= wait_cnt_d;
`endif
        end
    end

    assign imem_req  = imem_req_q;
    assign imem_addr = pc_q;
    assign opcode    = opcode_q;
    assign operand   = ir_q[INSTR_W-4:0];
    assign pc_out    = pc_q;
    assign halted    = halted_q;

`ifdef FETCH_TIMEOUT_EN
    assign fetch_err = err_q;
`else
    // Without the timeout feature nothing can set the flag.
    logic unused_err;
    assign unused_err = err_q;
    assign fetch_err  = 1'b0;
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Purpose : directed bench for instr_fetch_unit (INSTR_W=16, ADDR_W=8, RESET_PC=0, TIMEOUT=15).
// Latency : inputs driven and outputs sampled on the falling edge, DUT updates on the rising edge.
// Backpr. : stall and imem_valid latency are driven explicitly per instruction.

module tb_instr_fetch_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req;
    logic [7:0]  imem_addr;
    logic [15:0] imem_rdata;
    logic        imem_valid;
    logic        stall;
    logic        jmp_op;
    logic [2:0]  opcode;
    logic [12:0] operand;
    logic [7:0]  pc_out;
    logic        halted;
    logic        fetch_err;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    instr_fetch_unit #(
        .INSTR_W (16),
        .ADDR_W  (8),
        .RESET_PC(8'h00),
        .TIMEOUT (15)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .imem_req  (imem_req),
        .imem_addr (imem_addr),
        .imem_rdata(imem_rdata),
        .imem_valid(imem_valid),
        .stall     (stall),
        .jmp_op    (jmp_op),
        .opcode    (opcode),
        .operand   (operand),
        .pc_out    (pc_out),
        .halted    (halted),
        .fetch_err (fetch_err)
    );

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Runs one instruction starting in FETCH at address a; ends in the next FETCH.
    task automatic do_instr(input logic [15:0] w, input logic jmp, input int lat,
                            input int stl, input logic [7:0] a, input logic [7:0] nxt);
        check("req_fetch", imem_req, 1);
        check("addr_fetch", imem_addr, a);
        for (int i = 0; i < lat; i++) begin
            tick();
            check("req_wait", imem_req, 1);
            check("addr_stable", imem_addr, a);
            check("op_wait", opcode, 3'b101);
        end
        imem_valid = 1'b1;
        imem_rdata = w;
        tick();
        imem_valid = 1'b0;
        imem_rdata = 16'h0000;
        check("op_hold", opcode, 3'b101);
        check("req_hold", imem_req, 0);
        check("pc_out", pc_out, a);
        stall = (stl > 0);
        for (int i = 0; i < stl; i++) begin
            tick();
            check("op_stall", opcode, 3'b101);
        end
        stall = 1'b0;
        tick();
        check("op_issue", opcode, w[15:13]);
        check("operand", operand, w[12:0]);
        tick();
        check("op_resolve", opcode, 3'b101);
        jmp_op = jmp;
        tick();
        jmp_op = 1'b0;
        check("next_req", imem_req, 1);
        check("next_addr", imem_addr, nxt);
        check("not_halted", halted, 0);
    endtask

    initial begin
        rst        = 1'b1;
        imem_rdata = 16'h0000;
        imem_valid = 1'b0;
        stall      = 1'b0;
        jmp_op     = 1'b0;
        tick();
        tick();
        check("rst_req", imem_req, 0);
        check("rst_opcode", opcode, 3'b101);
        check("rst_halted", halted, 0);
        check("rst_err", fetch_err, 0);
        check("rst_pc", pc_out, 8'h00);
        rst = 1'b0;
        tick();

        // ADD at 0, zero latency, no jump: 4 cycles to the next fetch at 1.
        do_instr(16'h0000, 1'b0, 0, 0, 8'h00, 8'h01);
        do_instr(16'h2003, 1'b0, 0, 0, 8'h01, 8'h02);
        do_instr(16'h8005, 1'b1, 0, 0, 8'h02, 8'h05);
        // JUMP to 0x12 from pc=5.
        do_instr(16'h8012, 1'b1, 0, 0, 8'h05, 8'h12);
        // 5-cycle memory latency and 3 stall cycles, then jump to 0xFF.
        do_instr(16'h80FF, 1'b1, 5, 3, 8'h12, 8'hFF);
        // Non-jump at 0xFF wraps to 0.
        do_instr(16'h4000, 1'b0, 0, 0, 8'hFF, 8'h00);
        // Jump opcode but control unit declines: pc+1.
        do_instr(16'h8033, 1'b0, 1, 0, 8'h00, 8'h01);
        do_instr(16'h8007, 1'b1, 0, 0, 8'h01, 8'h07);

        // Reset in the middle of a fetch at 7; the response in the reset cycle is dropped.
        tick();
        tick();
        check("midfetch_addr", imem_addr, 8'h07);
        rst        = 1'b1;
        imem_valid = 1'b1;
        imem_rdata = 16'h2000;
        tick();
        check("midrst_req", imem_req, 0);
        check("midrst_opcode", opcode, 3'b101);
        check("midrst_pc", pc_out, 8'h00);
        rst        = 1'b0;
        imem_valid = 1'b0;
        imem_rdata = 16'h0000;
        tick();
        check("postrst_req", imem_req, 1);
        check("postrst_addr", imem_addr, 8'h00);
        check("postrst_halted", halted, 0);

        // HALT is fetched but never issued.
        imem_valid = 1'b1;
        imem_rdata = 16'hE000;
        tick();
        imem_valid = 1'b0;
        imem_rdata = 16'h0000;
        check("halt_hold_op", opcode, 3'b101);
        tick();
        check("halted", halted, 1);
        check("halt_req", imem_req, 0);
        check("halt_op", opcode, 3'b101);
        check("halt_err", fetch_err, 0);
        for (int i = 0; i < 4; i++) begin
            imem_valid = 1'b1;
            tick();
            check("halt_stays", halted, 1);
            check("halt_op_nop", opcode, 3'b101);
            check("halt_req_low", imem_req, 0);
        end
        imem_valid = 1'b0;
        rst        = 1'b1;
        tick();
        check("rst_clears_halt", halted, 0);
        rst = 1'b0;
        tick();
        check("refetch_req", imem_req, 1);
        check("refetch_addr", imem_addr, 8'h00);

        // Memory never answers.
`ifdef FETCH_TIMEOUT_EN
        for (int i = 0; i < 14; i++) begin
            tick();
            check("to_waiting", imem_req, 1);
            check("to_no_err", fetch_err, 0);
        end
        tick();
        check("to_err", fetch_err, 1);
        check("to_halted", halted, 1);
        check("to_req", imem_req, 0);
`else
        for (int i = 0; i < 20; i++) begin
            tick();
            check("wait_req", imem_req, 1);
            check("wait_addr", imem_addr, 8'h00);
            check("wait_no_err", fetch_err, 0);
            check("wait_no_halt", halted, 0);
        end
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
